long_op_scoreboard: RTL and testbench

Hazard scoreboard and issue controller for long-latency operations (integer divide, remote loads, FDIV/FSQRT, AMOs) in the vanilla core. Sits beside the ID stage: takes per-instruction register-use flags from the decoder, stalls issue on RAW/WAW hazards against pending long-latency writes, and caps outstanding long ops. Writeback paths retire entries through per-file clear ports; `empty_o` lets fence and barrier logic drain.

---
 rtl/long_op_scoreboard.sv | 109 ++++++++++
 tb/tb_long_op_scoreboard.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/long_op_scoreboard.sv
// Hazard scoreboard for long-latency ops: tracks pending integer/FP destination
// registers, stalls ID on RAW/WAW/capacity hazards, and retires entries on writeback.
module long_op_scoreboard #(
    parameter int reg_addr_width_p = 5,
    parameter int max_out_p        = 16,
    parameter int cnt_width_p      = $clog2(max_out_p + 1)
) (
    input  logic                                clk_i,
    input  logic                                reset_n_i,
    input  logic                                issue_v_i,
    input  logic                                is_long_op_i,
    input  logic [reg_addr_width_p-1:0]         rs1_i,
    input  logic [reg_addr_width_p-1:0]         rs2_i,
    input  logic [reg_addr_width_p-1:0]         rs3_i,
    input  logic [reg_addr_width_p-1:0]         rd_i,
    input  logic                                read_rs1_i,
    input  logic                                read_rs2_i,
    input  logic                                write_rd_i,
    input  logic                                read_frs1_i,
    input  logic                                read_frs2_i,
    input  logic                                read_frs3_i,
    input  logic                                write_frd_i,
    input  logic                                int_clear_v_i,
    input  logic [reg_addr_width_p-1:0]         int_clear_id_i,
    input  logic                                fp_clear_v_i,
    input  logic [reg_addr_width_p-1:0]         fp_clear_id_i,
    output logic                                stall_raw_o,
    output logic                                stall_waw_o,
    output logic                                stall_full_o,
    output logic                                stall_o,
    output logic [cnt_width_p-1:0]              pending_cnt_o,
    output logic                                empty_o,
    output logic [(2**reg_addr_width_p)-1:0]    int_pending_o,
    output logic [(2**reg_addr_width_p)-1:0]    fp_pending_o
);

    localparam int NumRegs = 2 ** reg_addr_width_p;
    localparam logic [cnt_width_p-1:0] MaxCnt = cnt_width_p'(max_out_p);

    typedef logic [NumRegs-1:0] vec_t;

    vec_t                 int_sb_q, int_sb_d, fp_sb_q, fp_sb_d;
    logic [cnt_width_p-1:0] cnt_q, cnt_d;

    vec_t                 int_clr_oh, fp_clr_oh, int_eff, fp_eff, int_set_oh, fp_set_oh;
    logic                 int_clr_hit, fp_clr_hit;
    logic                 raw, waw, full, fire, set_int, set_fp;
    logic [cnt_width_p:0] cnt_sum;

    always_comb begin
        // Writeback bypass: a register retiring this cycle is already free for hazard checks.
        int_clr_oh  = int_clear_v_i ? (vec_t'(1) << int_clear_id_i) : '0;
        fp_clr_oh   = fp_clear_v_i  ? (vec_t'(1) << fp_clear_id_i)  : '0;
        int_eff     = int_sb_q & ~int_clr_oh;
        fp_eff      = fp_sb_q  & ~fp_clr_oh;
        int_clr_hit = int_clear_v_i & int_sb_q[int_clear_id_i];
        fp_clr_hit  = fp_clear_v_i  & fp_sb_q[fp_clear_id_i];

        raw  = (read_rs1_i  & int_eff[rs1_i]) | (read_rs2_i  & int_eff[rs2_i]) |
               (read_frs1_i & fp_eff[rs1_i])  | (read_frs2_i & fp_eff[rs2_i])  |
               (read_frs3_i & fp_eff[rs3_i]);
        waw  = (write_rd_i & int_eff[rd_i]) | (write_frd_i & fp_eff[rd_i]);
        full = is_long_op_i & (cnt_q == MaxCnt) & ~int_clr_hit & ~fp_clr_hit;

        stall_raw_o  = issue_v_i & raw;
        stall_waw_o  = issue_v_i & waw;
        stall_full_o = issue_v_i & full;
        stall_o      = stall_raw_o | stall_waw_o | stall_full_o;

        fire    = issue_v_i & ~stall_o;
        set_int = fire & is_long_op_i & write_rd_i & (rd_i != '0);
        set_fp  = fire & is_long_op_i & write_frd_i;
        int_set_oh = set_int ? (vec_t'(1) << rd_i) : '0;
        fp_set_oh  = set_fp  ? (vec_t'(1) << rd_i) : '0;

        // Set after clear so a same-cycle set/clear of one register leaves it pending.
        int_sb_d = (int_eff | int_set_oh) & ~vec_t'(1);
        fp_sb_d  = fp_eff | fp_set_oh;

        cnt_sum = {1'b0, cnt_q} + (cnt_width_p+1)'(set_int) + (cnt_width_p+1)'(set_fp)
                - (cnt_width_p+1)'(int_clr_hit) - (cnt_width_p+1)'(fp_clr_hit);
        cnt_d   = cnt_sum[cnt_width_p-1:0];
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            int_sb_q <= '0;
            fp_sb_q  <= '0;
            cnt_q    <= '0;
        end else begin
            int_sb_q <= int_sb_d;
            fp_sb_q  <= fp_sb_d;
            cnt_q    <= cnt_d;
        end
    end

    assign pending_cnt_o = cnt_q;
    assign empty_o       = (cnt_q == '0);
    assign int_pending_o = int_sb_q;
    assign fp_pending_o  = fp_sb_q;

    int_clear_pending_a: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        int_clear_v_i |-> int_sb_q[int_clear_id_i]);
    fp_clear_pending_a: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        fp_clear_v_i |-> fp_sb_q[fp_clear_id_i]);
    cnt_range_a: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        cnt_sum <= {1'b0, MaxCnt});

endmodule

// File: tb/tb_long_op_scoreboard.sv
// Randomized + directed bench for long_op_scoreboard against a pending-set model.
module tb_long_op_scoreboard;
    localparam int AW = 5, NR = 32, MAXO = 4, CW = 3;

    logic clk_i = 1'b0, reset_n_i;
    logic issue_v_i, is_long_op_i;
    logic [AW-1:0] rs1_i, rs2_i, rs3_i, rd_i, int_clear_id_i, fp_clear_id_i;
    logic read_rs1_i, read_rs2_i, write_rd_i, read_frs1_i, read_frs2_i, read_frs3_i, write_frd_i;
    logic int_clear_v_i, fp_clear_v_i;
    logic stall_raw_o, stall_waw_o, stall_full_o, stall_o, empty_o;
    logic [CW-1:0] pending_cnt_o;
    logic [NR-1:0] int_pending_o, fp_pending_o;

    always #5 clk_i = ~clk_i;

    long_op_scoreboard #(.reg_addr_width_p(AW), .max_out_p(MAXO), .cnt_width_p(CW)) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .issue_v_i(issue_v_i), .is_long_op_i(is_long_op_i),
        .rs1_i(rs1_i), .rs2_i(rs2_i), .rs3_i(rs3_i), .rd_i(rd_i),
        .read_rs1_i(read_rs1_i), .read_rs2_i(read_rs2_i), .write_rd_i(write_rd_i),
        .read_frs1_i(read_frs1_i), .read_frs2_i(read_frs2_i), .read_frs3_i(read_frs3_i),
        .write_frd_i(write_frd_i), .int_clear_v_i(int_clear_v_i), .int_clear_id_i(int_clear_id_i),
        .fp_clear_v_i(fp_clear_v_i), .fp_clear_id_i(fp_clear_id_i),
        .stall_raw_o(stall_raw_o), .stall_waw_o(stall_waw_o), .stall_full_o(stall_full_o),
        .stall_o(stall_o), .pending_cnt_o(pending_cnt_o), .empty_o(empty_o),
        .int_pending_o(int_pending_o), .fp_pending_o(fp_pending_o));

    // Model: the set of pending destination registers per file; the count is its size.
    bit m_int[NR], m_fp[NR];
    int n_vec = 0, n_bad = 0;
    bit e_raw, e_waw, e_full, e_stall;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int m_cnt();
        int c = 0;
        for (int i = 0; i < NR; i++) c += int'(m_int[i]) + int'(m_fp[i]);
        return c;
    endfunction

    function automatic bit ibusy(input logic [AW-1:0] r);
        return m_int[r] && !(int_clear_v_i && int_clear_id_i == r);
    endfunction

    function automatic bit fbusy(input logic [AW-1:0] r);
        return m_fp[r] && !(fp_clear_v_i && fp_clear_id_i == r);
    endfunction

    function automatic logic [NR-1:0] pack(input bit fp);
        logic [NR-1:0] v;
        for (int i = 0; i < NR; i++) v[i] = fp ? m_fp[i] : m_int[i];
        return v;
    endfunction

    task automatic idle();
        issue_v_i = 0; is_long_op_i = 0;
        rs1_i = 0; rs2_i = 0; rs3_i = 0; rd_i = 0;
        read_rs1_i = 0; read_rs2_i = 0; write_rd_i = 0;
        read_frs1_i = 0; read_frs2_i = 0; read_frs3_i = 0; write_frd_i = 0;
        int_clear_v_i = 0; int_clear_id_i = 0; fp_clear_v_i = 0; fp_clear_id_i = 0;
    endtask

    task automatic model_eval();
        bit raw, waw, full, slot_freed;
        raw = (read_rs1_i && ibusy(rs1_i)) || (read_rs2_i && ibusy(rs2_i)) ||
              (read_frs1_i && fbusy(rs1_i)) || (read_frs2_i && fbusy(rs2_i)) ||
              (read_frs3_i && fbusy(rs3_i));
        waw = (write_rd_i && ibusy(rd_i)) || (write_frd_i && fbusy(rd_i));
        slot_freed = (int_clear_v_i && m_int[int_clear_id_i]) || (fp_clear_v_i && m_fp[fp_clear_id_i]);
        full = is_long_op_i && m_cnt() == MAXO && !slot_freed;
        e_raw   = issue_v_i && raw;
        e_waw   = issue_v_i && waw;
        e_full  = issue_v_i && full;
        e_stall = e_raw || e_waw || e_full;
    endtask

    task automatic check_all();
        chk("stall_raw", stall_raw_o, e_raw);
        chk("stall_waw", stall_waw_o, e_waw);
        chk("stall_full", stall_full_o, e_full);
        chk("stall", stall_o, e_stall);
        chk("pending_cnt", pending_cnt_o, m_cnt());
        chk("empty", empty_o, m_cnt() == 0);
        chk("int_pending", int_pending_o, pack(0));
        chk("fp_pending", fp_pending_o, pack(1));
    endtask

    task automatic model_commit();
        bit fire;
        fire = issue_v_i && !e_stall;
        if (int_clear_v_i) m_int[int_clear_id_i] = 0;
        if (fp_clear_v_i)  m_fp[fp_clear_id_i] = 0;
        if (fire && is_long_op_i && write_rd_i && rd_i != 0) m_int[rd_i] = 1;
        if (fire && is_long_op_i && write_frd_i) m_fp[rd_i] = 1;
    endtask

    task automatic run_cycle();
        #1;
        model_eval();
        check_all();
        @(posedge clk_i);
        model_commit();
        #1;
    endtask

    task automatic issue_long(input bit fp, input int r);
        idle(); issue_v_i = 1; is_long_op_i = 1; rd_i = AW'(r);
        if (fp) write_frd_i = 1; else write_rd_i = 1;
        run_cycle();
    endtask

    initial begin
        int qi[$], qf[$];
        idle();
        reset_n_i = 0;
        for (int i = 0; i < NR; i++) begin m_int[i] = 0; m_fp[i] = 0; end
        #3;
        chk("rst_empty", empty_o, 1);
        chk("rst_cnt", pending_cnt_o, 0);
        chk("rst_ivec", int_pending_o, 0);
        #9 reset_n_i = 1;
        @(posedge clk_i); #1;

        // RAW on x5, released by same-cycle writeback.
        issue_long(0, 5);
        idle(); issue_v_i = 1; read_rs1_i = 1; rs1_i = 5;
        #1 chk("raw_x5", stall_raw_o, 1); chk("cnt_x5", pending_cnt_o, 1);
        run_cycle();
        int_clear_v_i = 1; int_clear_id_i = 5;
        #1 chk("raw_bypass", stall_o, 0);
        run_cycle();
        idle(); #1 chk("empty_after_clr", empty_o, 1);

        // WAW on f3; integer x3 reads are unaffected.
        issue_long(1, 3);
        idle(); issue_v_i = 1; is_long_op_i = 1; write_frd_i = 1; rd_i = 3;
        #1 chk("waw_f3", stall_waw_o, 1);
        run_cycle(); run_cycle();
        idle(); issue_v_i = 1; read_rs1_i = 1; read_rs2_i = 1; rs1_i = 3; rs2_i = 3;
        #1 chk("int_x3_free", stall_o, 0);
        run_cycle();
        idle(); issue_v_i = 1; is_long_op_i = 1; write_frd_i = 1; rd_i = 3;
        fp_clear_v_i = 1; fp_clear_id_i = 3;
        #1 chk("waw_bypass", stall_waw_o, 0);
        run_cycle();
        idle(); #1 chk("f3_reissued", fp_pending_o[3], 1);
        fp_clear_v_i = 1; fp_clear_id_i = 3; run_cycle();

        // Capacity limit, with a same-cycle clear freeing a slot.
        issue_long(0, 1); issue_long(0, 2); issue_long(1, 1); issue_long(1, 2);
        idle(); issue_v_i = 1; is_long_op_i = 1; write_rd_i = 1; rd_i = 6;
        #1 chk("full", stall_full_o, 1);
        run_cycle();
        int_clear_v_i = 1; int_clear_id_i = 1;
        #1 chk("full_freed", stall_full_o, 0);
        run_cycle();
        idle(); #1 chk("cnt_at_max", pending_cnt_o, MAXO);
        int_clear_v_i = 1; int_clear_id_i = 2; fp_clear_v_i = 1; fp_clear_id_i = 1; run_cycle();
        idle(); int_clear_v_i = 1; int_clear_id_i = 6; fp_clear_v_i = 1; fp_clear_id_i = 2; run_cycle();

        // x0 destination is never tracked and never hazards.
        issue_long(0, 0);
        idle(); issue_v_i = 1; read_rs1_i = 1; write_rd_i = 1;
        #1 chk("x0_cnt", pending_cnt_o, 0); chk("x0_stall", stall_o, 0);
        run_cycle();

        // Dual clear plus reissue of the cleared integer register.
        issue_long(0, 4); issue_long(1, 7);
        idle(); int_clear_v_i = 1; int_clear_id_i = 4; fp_clear_v_i = 1; fp_clear_id_i = 7;
        issue_v_i = 1; is_long_op_i = 1; write_rd_i = 1; rd_i = 4;
        run_cycle();
        idle(); #1 chk("dual_clr_cnt", pending_cnt_o, 1); chk("x4_set", int_pending_o[4], 1);
        int_clear_v_i = 1; int_clear_id_i = 4; run_cycle();

        // Asynchronous reset mid-cycle with entries pending.
        issue_long(0, 1); issue_long(0, 2); issue_long(1, 3);
        idle(); issue_v_i = 1; read_rs1_i = 1; rs1_i = 1;
        #1 chk("pre_rst_raw", stall_raw_o, 1);
        #1 reset_n_i = 0;
        for (int i = 0; i < NR; i++) begin m_int[i] = 0; m_fp[i] = 0; end
        #1 chk("rst_async_empty", empty_o, 1); chk("rst_async_cnt", pending_cnt_o, 0);
        chk("rst_async_ivec", int_pending_o, 0); chk("rst_async_fvec", fp_pending_o, 0);
        chk("rst_async_stall", stall_o, 0);
        @(negedge clk_i); reset_n_i = 1;
        @(posedge clk_i); #1;

        // Random traffic over a small register window to provoke hazards.
        for (int n = 0; n < 600; n++) begin
            int w;
            idle();
            issue_v_i    = $urandom_range(0, 3) != 0;
            is_long_op_i = $urandom_range(0, 1) != 0;
            rs1_i = AW'($urandom_range(0, 7)); rs2_i = AW'($urandom_range(0, 7));
            rs3_i = AW'($urandom_range(0, 7)); rd_i  = AW'($urandom_range(0, 7));
            read_rs1_i  = $urandom_range(0, 1) != 0; read_rs2_i  = $urandom_range(0, 1) != 0;
            read_frs1_i = $urandom_range(0, 1) != 0; read_frs2_i = $urandom_range(0, 1) != 0;
            read_frs3_i = $urandom_range(0, 1) != 0;
            w = $urandom_range(0, 2);
            write_rd_i = (w == 1); write_frd_i = (w == 2);
            qi.delete(); qf.delete();
            for (int i = 0; i < NR; i++) begin
                if (m_int[i]) qi.push_back(i);
                if (m_fp[i])  qf.push_back(i);
            end
            if (qi.size() > 0 && $urandom_range(0, 2) == 0) begin
                int_clear_v_i = 1; int_clear_id_i = AW'(qi[$urandom_range(0, qi.size()-1)]);
            end
            if (qf.size() > 0 && $urandom_range(0, 2) == 0) begin
                fp_clear_v_i = 1; fp_clear_id_i = AW'(qf[$urandom_range(0, qf.size()-1)]);
            end
            run_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
